stack_mc_controller_v2: RTL and testbench
=========================================

Name: stack_mc_controller_v2

Overview:
Multi-cycle control FSM for the stack-based MIPS datapath, next generation of the stack controller. Adds a wider opcode field, OR/DUP/SWAP/HALT instructions and a memory-ready handshake on every memory access state. Adds internal stack-occupancy tracking, with sticky underflow, overflow and illegal-opcode faults. Sits between the IR opcode field and the datapath control lines of PC, memory, A/B registers, stack and ALU.

Parameters:
OPW, 4, opcode field width; must be >= 4. Upper OPW-4 bits must be zero for a legal opcode.
DEPTH, 16, number of stack entries.
CNTW, 5, width of the occupancy counter; must satisfy 2^CNTW > DEPTH.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
inst  in  OPW  opcode from IR
mem_ready  in  1  memory access completes this cycle
PcWrite, PcWriteC, PcSrc, PorI, MemRead, IRWrite, MemWrite, LdA, LdB, SrcA, SrcB, Push, Pop, toS  out  1 each  datapath controls, same meaning as the previous-generation controller
StkSrc  out  2  stack write-data select: 00 ALU, 01 memory, 10 A, 11 B
AluOp  out  3  ALU function: 000 add, 001 sub, 010 and, 011 not, 100 or
sp_count  out  CNTW  current stack occupancy
Halted  out  1  high in HALT
Fault  out  1  high in FAULT
FaultCode  out  2  fault cause: 01 underflow, 10 overflow, 11 illegal opcode; 00 otherwise

Behaviour:
- Opcode map (low 4 bits): 0 add, 1 sub, 2 and, 3 not, 4 push, 5 pop, 6 jmp, 7 jz, 8 or, 9 dup, A swap, B halt. C-F, or any nonzero upper bit, are illegal.
- Reset: ps=IF, sp_count=0, FaultCode=00.
- Outputs are Moore, decoded from state. The only exception is IF, which is gated by mem_ready. Any control not listed for a state is 0; StkSrc defaults to 00 and AluOp to 000.
- IF: MemRead, SrcA, SrcB, AluOp=000, PcSrc=0, PorI=0. PcWrite and IRWrite equal mem_ready. Hold in IF while mem_ready=0, else go to ID.
- ID: toS=1. Performs the occupancy check against sp_count, with priority illegal > underflow > overflow.
  - push: needs sp_count < DEPTH.
  - pop, not, jz: need >= 1.
  - dup: needs >= 1 and < DEPTH.
  - add, sub, and, or, swap: need >= 2.
  - jmp, halt: no requirement.
  - A failed check goes to FAULT and loads FaultCode.
  - Otherwise: push -> PUSH1, jmp -> JMP1, jz -> JZ1, halt -> HALT, all others -> O1.
- JMP1: PcSrc, PcWrite; -> IF.
- JZ1: PcSrc, PcWriteC; -> IF.
- PUSH1: PorI, MemRead. Hold while mem_ready=0, then -> PUSH2.
- PUSH2: Push, StkSrc=01; -> IF.
- O1: Pop; -> O2.
- O2: LdA. Next state: pop -> POP1, not -> NOT1, dup -> DUPA, others -> L1.
- POP1: PorI, MemWrite. Hold while mem_ready=0, then -> IF.
- NOT1: AluOp=011; -> PUSHG.
- L1: Pop; -> L2.
- L2: LdB. Next state: swap -> SWA, others -> L3.
- L3: AluOp from opcode (add/sub/and/or); -> PUSHG.
- PUSHG: Push, StkSrc=00; -> IF.
- DUPA: Push, StkSrc=10; -> DUPB.
- DUPB: Push, StkSrc=10; -> IF.
- SWA: Push, StkSrc=10; -> SWB.
- SWB: Push, StkSrc=11; -> IF. Net effect: the former second entry is now on top.
- HALT: Halted=1, all other controls 0; absorbing until rst.
- FAULT: Fault=1, all other controls 0; FaultCode held; absorbing until rst.
- sp_count: +1 in every cycle Push=1, -1 in every cycle Pop=1. Push and Pop are never asserted together. The ID checks guarantee no wrap.
- rst mid-instruction, including during a mem_ready wait, returns to IF immediately with sp_count=0.
- Undefined state encodings -> IF with all controls 0.
- inst must be stable from ID to instruction end; the FSM does not latch it.

Test Plan:
- Reset, then push with mem_ready=1 -> states IF,ID,PUSH1,PUSH2 (4 cycles), one Push with StkSrc=01, sp_count 0->1.
- Two pushes then add -> 8-cycle add sequence, two Pops, L3 AluOp=000, PUSHG Push, sp_count 2->1. Repeat with or -> L3 AluOp=100.
- mem_ready=0 for 3 cycles in IF and in PUSH1 -> state holds, PcWrite=IRWrite=0 while waiting, then advances on the cycle mem_ready=1.
- Push 5, push 7, swap -> SWA Push StkSrc=10, SWB Push StkSrc=11, sp_count returns to 2. dup -> sp_count 3.
- From reset, add -> FAULT, FaultCode=01. 16 pushes then push -> FaultCode=10. inst=4'hD -> FaultCode=11. Each is sticky until rst, which restores IF and sp_count=0.
- halt -> Halted=1 and held for 10 cycles with all controls 0. Assert rst during a POP1 mem_ready wait -> IF next, sp_count=0.

Source files
------------

// File: rtl/stack_mc_controller_v2.sv
// -----------------------------------------------------------------------------
// stack_mc_controller_v2
//
// Multi-cycle control FSM for the stack-based MIPS datapath. It decodes the IR
// opcode field, sequences the datapath through fetch, decode and execute states,
// tracks stack occupancy, and traps underflow, overflow and illegal-opcode
// conditions into a sticky FAULT state.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   inst       opcode from IR (must stay stable from ID until the instruction ends)
//   mem_ready  memory access completes this cycle
//   PcWrite, PcWriteC, PcSrc, PorI, MemRead, IRWrite, MemWrite,
//   LdA, LdB, SrcA, SrcB, Push, Pop, toS      single-bit datapath controls
//   StkSrc     stack write-data select: 00 ALU, 01 memory, 10 A, 11 B
//   AluOp      ALU function: 000 add, 001 sub, 010 and, 011 not, 100 or
//   sp_count   current stack occupancy
//   Halted     high in HALT
//   Fault      high in FAULT
//   FaultCode  01 underflow, 10 overflow, 11 illegal opcode, 00 otherwise
// -----------------------------------------------------------------------------
module stack_mc_controller_v2 #(
  parameter int OPW   = 4,
  parameter int DEPTH = 16,
  parameter int CNTW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  inst,
  input  logic            mem_ready,
  output logic            PcWrite,
  output logic            PcWriteC,
  output logic            PcSrc,
  output logic            PorI,
  output logic            MemRead,
  output logic            IRWrite,
  output logic            MemWrite,
  output logic            LdA,
  output logic            LdB,
  output logic            SrcA,
  output logic            SrcB,
  output logic            Push,
  output logic            Pop,
  output logic            toS,
  output logic [1:0]      StkSrc,
  output logic [2:0]      AluOp,
  output logic [CNTW-1:0] sp_count,
  output logic            Halted,
  output logic            Fault,
  output logic [1:0]      FaultCode
);

  typedef enum logic [4:0] {
    S_IF, S_ID, S_JMP1, S_JZ1, S_PUSH1, S_PUSH2, S_O1, S_O2, S_POP1, S_NOT1,
    S_L1, S_L2, S_L3, S_PUSHG, S_DUPA, S_DUPB, S_SWA, S_SWB, S_HALT, S_FAULT
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND = 4'h2, OP_NOT  = 4'h3,
    OP_PUSH = 4'h4, OP_POP  = 4'h5, OP_JMP = 4'h6, OP_JZ   = 4'h7,
    OP_OR   = 4'h8, OP_DUP  = 4'h9, OP_SWAP = 4'hA, OP_HALT = 4'hB
  } op_t;

  localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);
  localparam logic [CNTW-1:0] TWO_C   = CNTW'(2);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  state_t     ps, ns;
  op_t        op;
  logic       upper_nz;
  logic       legal, need1, need2, need_room;
  logic [1:0] id_fault;

  assign op       = op_t'(inst[3:0]);
  // Any set bit above the 4-bit opcode makes the instruction illegal.
  assign upper_nz = |(inst >> 4);

  // Occupancy check performed in ID; priority illegal > underflow > overflow.
  always_comb begin
    legal     = !upper_nz;
    need1     = 1'b0;
    need2     = 1'b0;
    need_room = 1'b0;
    case (op)
      OP_PUSH:                                need_room = 1'b1;
      OP_POP, OP_NOT, OP_JZ:                  need1     = 1'b1;
      OP_DUP:                                 begin need1 = 1'b1; need_room = 1'b1; end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SWAP: need2     = 1'b1;
      OP_JMP, OP_HALT:                        ;
      default:                                legal     = 1'b0;
    endcase

    if (!legal)
      id_fault = 2'b11;
    else if ((need1 && sp_count < ONE_C) || (need2 && sp_count < TWO_C))
      id_fault = 2'b01;
    else if (need_room && sp_count >= DEPTH_C)
      id_fault = 2'b10;
    else
      id_fault = 2'b00;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    ns       = ps;
    PcWrite  = 1'b0;
    PcWriteC = 1'b0;
    PcSrc    = 1'b0;
    PorI     = 1'b0;
    MemRead  = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    LdA      = 1'b0;
    LdB      = 1'b0;
    SrcA     = 1'b0;
    SrcB     = 1'b0;
    Push     = 1'b0;
    Pop      = 1'b0;
    toS      = 1'b0;
    StkSrc   = 2'b00;
    AluOp    = 3'b000;
    Halted   = 1'b0;
    Fault    = 1'b0;

    case (ps)
      S_IF: begin
        MemRead = 1'b1;
        SrcA    = 1'b1;
        SrcB    = 1'b1;
        // PC increment and IR load only happen on the cycle the fetch completes.
        PcWrite = mem_ready;
        IRWrite = mem_ready;
        ns      = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        toS = 1'b1;
        if (id_fault != 2'b00) ns = S_FAULT;
        else begin
          case (op)
            OP_PUSH: ns = S_PUSH1;
            OP_JMP:  ns = S_JMP1;
            OP_JZ:   ns = S_JZ1;
            OP_HALT: ns = S_HALT;
            default: ns = S_O1;
          endcase
        end
      end
      S_JMP1: begin PcSrc = 1'b1; PcWrite  = 1'b1; ns = S_IF; end
      S_JZ1:  begin PcSrc = 1'b1; PcWriteC = 1'b1; ns = S_IF; end
      S_PUSH1: begin
        PorI    = 1'b1;
        MemRead = 1'b1;
        ns      = mem_ready ? S_PUSH2 : S_PUSH1;
      end
      S_PUSH2: begin Push = 1'b1; StkSrc = 2'b01; ns = S_IF; end
      S_O1:    begin Pop = 1'b1; ns = S_O2; end
      S_O2: begin
        LdA = 1'b1;
        case (op)
          OP_POP:  ns = S_POP1;
          OP_NOT:  ns = S_NOT1;
          OP_DUP:  ns = S_DUPA;
          default: ns = S_L1;
        endcase
      end
      S_POP1: begin
        PorI     = 1'b1;
        MemWrite = 1'b1;
        ns       = mem_ready ? S_IF : S_POP1;
      end
      S_NOT1: begin AluOp = 3'b011; ns = S_PUSHG; end
      S_L1:   begin Pop = 1'b1; ns = S_L2; end
      S_L2: begin
        LdB = 1'b1;
        ns  = (op == OP_SWAP) ? S_SWA : S_L3;
      end
      S_L3: begin
        case (op)
          OP_SUB:  AluOp = 3'b001;
          OP_AND:  AluOp = 3'b010;
          OP_OR:   AluOp = 3'b100;
          default: AluOp = 3'b000;
        endcase
        ns = S_PUSHG;
      end
      S_PUSHG: begin Push = 1'b1; StkSrc = 2'b00; ns = S_IF; end
      S_DUPA:  begin Push = 1'b1; StkSrc = 2'b10; ns = S_DUPB; end
      S_DUPB:  begin Push = 1'b1; StkSrc = 2'b10; ns = S_IF; end
      // A holds the old top, B the old second: pushing A then B leaves the
      // former second entry on top.
      S_SWA:   begin Push = 1'b1; StkSrc = 2'b10; ns = S_SWB; end
      S_SWB:   begin Push = 1'b1; StkSrc = 2'b11; ns = S_IF; end
      S_HALT:  begin Halted = 1'b1; ns = S_HALT; end
      S_FAULT: begin Fault  = 1'b1; ns = S_FAULT; end
      default: ns = S_IF;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps        <= S_IF;
      sp_count  <= '0;
      FaultCode <= 2'b00;
    end else begin
      ps <= ns;
      if (ps == S_ID && id_fault != 2'b00)
        FaultCode <= id_fault;
      if (Push)
        sp_count <= sp_count + ONE_C;
      else if (Pop)
        sp_count <= sp_count - ONE_C;
    end
  end

endmodule

// File: tb/tb_stack_mc_controller_v2.sv
// -----------------------------------------------------------------------------
// tb_stack_mc_controller_v2
//
// Scoreboard bench for stack_mc_controller_v2. The stimulus process drives one
// cycle at a time and pushes the expected output snapshot for that cycle into a
// queue; a monitor pops and compares on each falling edge. The DUT is built with
// OPW=5 so opcodes with a nonzero upper bit can be exercised.
// -----------------------------------------------------------------------------
module tb_stack_mc_controller_v2;

  localparam int OPW = 5;

  typedef enum {
    E_IF, E_ID, E_JMP1, E_JZ1, E_PUSH1, E_PUSH2, E_O1, E_O2, E_POP1, E_NOT1,
    E_L1, E_L2, E_L3, E_PUSHG, E_DUPA, E_DUPB, E_SWA, E_SWB, E_HALT, E_FAULT
  } est_t;

  typedef struct packed {
    logic pc_write, pc_write_c, pc_src, por_i, mem_read, ir_write, mem_write;
    logic ld_a, ld_b, src_a, src_b, push, pop, to_s;
    logic [1:0] stk_src;
    logic [2:0] alu_op;
    logic       halted, fault;
    logic [1:0] fault_code;
    logic [4:0] sp;
  } obs_t;

  typedef struct {
    obs_t  v;
    string tag;
  } exp_t;

  localparam logic [OPW-1:0] I_ADD = 5'h00, I_SUB = 5'h01, I_AND = 5'h02,
                             I_NOT = 5'h03, I_PUSH = 5'h04, I_POP = 5'h05,
                             I_JMP = 5'h06, I_JZ = 5'h07, I_OR = 5'h08,
                             I_DUP = 5'h09, I_SWAP = 5'h0A, I_HALT = 5'h0B;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [OPW-1:0] inst = '0;
  logic           mem_ready = 1'b0;
  logic PcWrite, PcWriteC, PcSrc, PorI, MemRead, IRWrite, MemWrite;
  logic LdA, LdB, SrcA, SrcB, Push, Pop, toS;
  logic [1:0] StkSrc;
  logic [2:0] AluOp;
  logic [4:0] sp_count;
  logic       Halted, Fault;
  logic [1:0] FaultCode;

  stack_mc_controller_v2 #(.OPW(OPW), .DEPTH(16), .CNTW(5)) dut (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready),
    .PcWrite(PcWrite), .PcWriteC(PcWriteC), .PcSrc(PcSrc), .PorI(PorI),
    .MemRead(MemRead), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .LdA(LdA), .LdB(LdB), .SrcA(SrcA), .SrcB(SrcB),
    .Push(Push), .Pop(Pop), .toS(toS), .StkSrc(StkSrc), .AluOp(AluOp),
    .sp_count(sp_count), .Halted(Halted), .Fault(Fault), .FaultCode(FaultCode)
  );

  always #5 clk = ~clk;

  obs_t act;
  assign act = {PcWrite, PcWriteC, PcSrc, PorI, MemRead, IRWrite, MemWrite,
                LdA, LdB, SrcA, SrcB, Push, Pop, toS, StkSrc, AluOp,
                Halted, Fault, FaultCode, sp_count};

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] cur_sp   = '0;
  logic [1:0] cur_fc   = 2'b00;

  // Expected controls for each state, straight from the state table.
  function automatic obs_t exp_of(input est_t st, input logic mr, input logic [2:0] aop,
                                  input logic [4:0] sp, input logic [1:0] fc);
    obs_t o;
    o = '0;
    o.sp = sp;
    o.fault_code = fc;
    case (st)
      E_IF:    begin o.mem_read = 1; o.src_a = 1; o.src_b = 1; o.pc_write = mr; o.ir_write = mr; end
      E_ID:    o.to_s = 1;
      E_JMP1:  begin o.pc_src = 1; o.pc_write = 1; end
      E_JZ1:   begin o.pc_src = 1; o.pc_write_c = 1; end
      E_PUSH1: begin o.por_i = 1; o.mem_read = 1; end
      E_PUSH2: begin o.push = 1; o.stk_src = 2'b01; end
      E_O1:    o.pop = 1;
      E_O2:    o.ld_a = 1;
      E_POP1:  begin o.por_i = 1; o.mem_write = 1; end
      E_NOT1:  o.alu_op = 3'b011;
      E_L1:    o.pop = 1;
      E_L2:    o.ld_b = 1;
      E_L3:    o.alu_op = aop;
      E_PUSHG: o.push = 1;
      E_DUPA:  begin o.push = 1; o.stk_src = 2'b10; end
      E_DUPB:  begin o.push = 1; o.stk_src = 2'b10; end
      E_SWA:   begin o.push = 1; o.stk_src = 2'b10; end
      E_SWB:   begin o.push = 1; o.stk_src = 2'b11; end
      E_HALT:  o.halted = 1;
      E_FAULT: o.fault = 1;
      default: ;
    endcase
    return o;
  endfunction

  // Drive one cycle and queue what the DUT should show during it.
  task automatic cyc(input est_t st, input logic [OPW-1:0] i, input logic mr,
                     input logic [2:0] aop, input logic r, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    inst      = i;
    mem_ready = mr;
    if (r) begin
      cur_sp = '0;
      cur_fc = 2'b00;
    end
    e.v   = exp_of(st, mr, aop, cur_sp, cur_fc);
    e.tag = tag;
    exp_q.push_back(e);
    if (e.v.push) cur_sp = cur_sp + 5'd1;
    if (e.v.pop)  cur_sp = cur_sp - 5'd1;
  endtask

  task automatic c(input est_t st, input logic [OPW-1:0] i, input string tag);
    cyc(st, i, 1'b1, 3'b000, 1'b0, tag);
  endtask

  task automatic reset_cycle(input string tag);
    cyc(E_IF, '0, 1'b0, 3'b000, 1'b1, tag);
  endtask

  task automatic run_push(input string tag);
    c(E_IF, I_PUSH, {tag, "_if"});
    c(E_ID, I_PUSH, {tag, "_id"});
    c(E_PUSH1, I_PUSH, {tag, "_push1"});
    c(E_PUSH2, I_PUSH, {tag, "_push2"});
  endtask

  task automatic run_binop(input logic [OPW-1:0] i, input logic [2:0] aop, input string tag);
    c(E_IF, i, {tag, "_if"});
    c(E_ID, i, {tag, "_id"});
    c(E_O1, i, {tag, "_o1"});
    c(E_O2, i, {tag, "_o2"});
    c(E_L1, i, {tag, "_l1"});
    c(E_L2, i, {tag, "_l2"});
    cyc(E_L3, i, 1'b1, aop, 1'b0, {tag, "_l3"});
    c(E_PUSHG, i, {tag, "_pushg"});
  endtask

  task automatic run_fault(input logic [OPW-1:0] i, input logic [1:0] code, input string tag);
    c(E_IF, i, {tag, "_if"});
    c(E_ID, i, {tag, "_id"});
    cur_fc = code;
    c(E_FAULT, i, {tag, "_fault"});
    c(E_FAULT, I_PUSH, {tag, "_sticky1"});
    cyc(E_FAULT, I_NOT, 1'b0, 3'b000, 1'b0, {tag, "_sticky2"});
    reset_cycle({tag, "_rst"});
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: actual=%h required=%h", e.tag, act, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_cycle("rst0");
    reset_cycle("rst1");

    // Basic push, then arithmetic through the two-operand path.
    run_push("p1");
    run_push("p2");
    run_binop(I_ADD, 3'b000, "add");
    run_push("p3");
    run_binop(I_OR, 3'b100, "or");

    // Fetch and push-data stalls on mem_ready.
    for (int k = 0; k < 3; k++) cyc(E_IF, I_PUSH, 1'b0, 3'b000, 1'b0, "stall_if");
    c(E_IF, I_PUSH, "stall_if_go");
    c(E_ID, I_PUSH, "stall_id");
    for (int k = 0; k < 3; k++) cyc(E_PUSH1, I_PUSH, 1'b0, 3'b000, 1'b0, "stall_push1");
    c(E_PUSH1, I_PUSH, "stall_push1_go");
    c(E_PUSH2, I_PUSH, "stall_push2");

    // swap (occupancy 2 -> 2), dup (2 -> 3), not, jz, jmp, sub, and.
    c(E_IF, I_SWAP, "swap_if");  c(E_ID, I_SWAP, "swap_id");
    c(E_O1, I_SWAP, "swap_o1");  c(E_O2, I_SWAP, "swap_o2");
    c(E_L1, I_SWAP, "swap_l1");  c(E_L2, I_SWAP, "swap_l2");
    c(E_SWA, I_SWAP, "swap_swa"); c(E_SWB, I_SWAP, "swap_swb");
    c(E_IF, I_DUP, "dup_if");    c(E_ID, I_DUP, "dup_id");
    c(E_O1, I_DUP, "dup_o1");    c(E_O2, I_DUP, "dup_o2");
    c(E_DUPA, I_DUP, "dup_a");   c(E_DUPB, I_DUP, "dup_b");
    c(E_IF, I_NOT, "not_if");    c(E_ID, I_NOT, "not_id");
    c(E_O1, I_NOT, "not_o1");    c(E_O2, I_NOT, "not_o2");
    c(E_NOT1, I_NOT, "not_1");   c(E_PUSHG, I_NOT, "not_pushg");
    c(E_IF, I_JZ, "jz_if");      c(E_ID, I_JZ, "jz_id");      c(E_JZ1, I_JZ, "jz_1");
    c(E_IF, I_JMP, "jmp_if");    c(E_ID, I_JMP, "jmp_id");    c(E_JMP1, I_JMP, "jmp_1");
    run_binop(I_SUB, 3'b001, "sub");
    run_binop(I_AND, 3'b010, "and");

    // Pop with a completed store, then a pop interrupted by reset mid-wait.
    c(E_IF, I_POP, "pop_if");    c(E_ID, I_POP, "pop_id");
    c(E_O1, I_POP, "pop_o1");    c(E_O2, I_POP, "pop_o2");
    c(E_POP1, I_POP, "pop_1");
    c(E_IF, I_POP, "pop_done");
    c(E_ID, I_POP, "pop2_id");
    c(E_PUSH1, I_POP, "pop2_push1_mislabel");
    exp_q.delete();
    reset_cycle("resync_rst");
    run_push("pr");
    c(E_IF, I_POP, "popr_if");   c(E_ID, I_POP, "popr_id");
    c(E_O1, I_POP, "popr_o1");   c(E_O2, I_POP, "popr_o2");
    cyc(E_POP1, I_POP, 1'b0, 3'b000, 1'b0, "popr_wait1");
    cyc(E_POP1, I_POP, 1'b0, 3'b000, 1'b0, "popr_wait2");
    reset_cycle("popr_rst");
    run_push("after_rst");
    reset_cycle("rst2");

    // Faults: underflow, overflow, illegal low code, illegal upper bit,
    // and illegal taking priority over underflow.
    run_fault(I_ADD, 2'b01, "uflow");
    for (int k = 0; k < 16; k++) run_push("fill");
    run_fault(I_PUSH, 2'b10, "oflow");
    run_fault(5'h0D, 2'b11, "illegal_d");
    run_fault(5'h14, 2'b11, "illegal_hi");
    run_fault(5'h10, 2'b11, "illegal_prio");

    // HALT absorbs regardless of inputs.
    c(E_IF, I_HALT, "halt_if");
    c(E_ID, I_HALT, "halt_id");
    for (int k = 0; k < 10; k++)
      cyc(E_HALT, 5'(k), k[0], 3'b000, 1'b0, "halt_hold");
    reset_cycle("halt_rst");
    c(E_IF, I_PUSH, "final_if");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
